// File: rtl/ram_src_stream.sv
// ram_src_stream: single-clock RAM, host-filled over an Avalon-MM slave and read out by a
// burst engine as a valid/ready word stream.
//
// Ports:
//   clk, reset_n          clock and synchronous active-low reset
//   write_n, address,     Avalon-MM slave: active-low write strobe, word address,
//   writedata, readdata   write data, read data (ram[address of previous cycle])
//   byteenable            byte-lane write enables (only with RAM_SRC_BYTEEN_EN)
//   start, start_addr,    burst request (sampled in idle), first word address,
//   length                burst length in words (0..2**W)
//   abort                 cancel a burst in progress, no done pulse
//   busy, done            burst in progress, 1-cycle pulse on normal completion
//   out_data, out_valid,  stream output; a word is accepted when out_valid & out_ready
//   out_ready
//
// Build option: define RAM_SRC_BYTEEN_EN to add the byteenable port and per-lane writes.
module ram_src_stream #(
  parameter int unsigned B = 32,
  parameter int unsigned W = 10
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           write_n,
  input  logic [W-1:0]   address,
  input  logic [B-1:0]   writedata,
  output logic [B-1:0]   readdata,
`ifdef RAM_SRC_BYTEEN_EN
  input  logic [B/8-1:0] byteenable,
`endif
  input  logic           start,
  input  logic [W-1:0]   start_addr,
  input  logic [W:0]     length,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  output logic [B-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int unsigned Depth = 2 ** W;

  typedef enum logic [1:0] {StIdle, StLoad, StHold} state_e;

  logic [B-1:0] mem [Depth];

  logic [W-1:0] address_q;
  state_e       state_q, state_d;
  logic [W-1:0] rd_addr_q, rd_addr_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W:0]   remaining_q, remaining_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [B-1:0] out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;

  // Host port. RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!write_n) begin
`ifdef RAM_SRC_BYTEEN_EN
      for (int i = 0; i < int'(B / 8); i++) begin
        if (byteenable[i]) begin
          mem[address][8*i +: 8] <= writedata[8*i +: 8];
        end
      end
`else
      mem[address] <= writedata;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      address_q <= '0;
    end else begin
      address_q <= address;
    end
  end

  assign readdata = mem[address_q];

  // Burst engine next state. Abort overrides every state transition.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (abort) begin
      state_d     = StIdle;
      busy_d      = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            if (length != '0) begin
              rd_addr_d   = start_addr;
              ptr_d       = start_addr + W'(1);
              remaining_d = length;
              busy_d      = 1'b1;
              state_d     = StLoad;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        StLoad: begin
          // Read sees RAM before any host write landing on this same edge.
          out_data_d  = mem[rd_addr_q];
          out_valid_d = 1'b1;
          remaining_d = remaining_q - (W+1)'(1);
          rd_addr_d   = ptr_q;
          ptr_d       = ptr_q + W'(1);
          state_d     = StHold;
        end
        StHold: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            if (remaining_q != '0) begin
              state_d = StLoad;
            end else begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = StIdle;
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      rd_addr_q   <= '0;
      ptr_q       <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ram_src_stream.sv
// Self-checking bench for ram_src_stream (B=32, W=10). Inputs change on the falling edge,
// outputs are sampled on the falling edge. Expected stream words come from a host-side
// copy of the RAM; timing expectations come from the word-per-two-cycles protocol rules.
module tb_ram_src_stream;

  localparam int unsigned B = 32;
  localparam int unsigned W = 10;
  localparam int unsigned Depth = 1024;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           write_n;
  logic [W-1:0]   address;
  logic [B-1:0]   writedata;
  logic [B-1:0]   readdata;
`ifdef RAM_SRC_BYTEEN_EN
  logic [B/8-1:0] byteenable;
`endif
  logic           start;
  logic [W-1:0]   start_addr;
  logic [W:0]     length;
  logic           abort;
  logic           busy;
  logic           done;
  logic [B-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;

  int errors = 0;
  int checks = 0;

  logic [B-1:0] ram_model [Depth];

  always #5 clk = ~clk;

  ram_src_stream #(
    .B(B),
    .W(W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .write_n    (write_n),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
`ifdef RAM_SRC_BYTEEN_EN
    .byteenable (byteenable),
`endif
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  task automatic host_write(input logic [W-1:0] a, input logic [B-1:0] d,
                            input logic [B/8-1:0] be);
    write_n   = 1'b0;
    address   = a;
    writedata = d;
`ifdef RAM_SRC_BYTEEN_EN
    byteenable = be;
    for (int i = 0; i < int'(B / 8); i++) begin
      if (be[i]) ram_model[a][8*i +: 8] = d[8*i +: 8];
    end
`else
    ram_model[a] = d;
`endif
    @(negedge clk);
    write_n = 1'b1;
  endtask

  task automatic fill_ram();
    for (int i = 0; i < int'(Depth); i++) host_write(W'(i), $urandom, '1);
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;
`ifdef RAM_SRC_BYTEEN_EN
    byteenable = '1;
`endif
    start      = 1'b0;
    start_addr = '0;
    length     = '0;
    abort      = 1'b0;
    out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_host_rw();
    logic [W-1:0] a;
    for (int i = 0; i < 8; i++) host_write(W'(i), 32'hA0 + i, '1);
    address = 10'd3;
    @(negedge clk);
    checks++;
    if (readdata !== 32'h0000_00A3) begin
      errors++; $display("FAIL host_read3 got %h want 000000a3", readdata);
    end
    for (int j = 0; j < 6; j++) begin
      a = W'($urandom_range(0, Depth - 1));
      address = a;
      @(negedge clk);
      checks++;
      if (readdata !== ram_model[a]) begin
        errors++; $display("FAIL host_read addr=%0d got %h want %h", a, readdata, ram_model[a]);
      end
    end
  endtask

  task automatic test_write_visibility();
    logic [B-1:0] old_v, new_v;
    old_v = ram_model[700];
    new_v = ~old_v;
    address = 10'd700;
    @(negedge clk);
    checks++;
    if (readdata !== old_v) begin errors++; $display("FAIL wvis_old got %h want %h", readdata, old_v); end
    host_write(10'd700, new_v, '1);
    checks++;
    if (readdata !== new_v) begin errors++; $display("FAIL wvis_new got %h want %h", readdata, new_v); end
  endtask

  // Starts a burst at the current falling edge and follows it to its done pulse; returns on
  // the falling edge where done is seen so a following burst can start in the done cycle.
  task automatic run_burst(input logic [W-1:0] sa, input int len, input int stall_len,
                           input bit rand_ready, input int restart_k, input string name);
    logic [B-1:0] exp_q[$];
    logic [B-1:0] held;
    int k, hs_cnt, hs_k, first_k, exp_k;
    bit pending, finished, rdy;
    for (int i = 0; i < len; i++) exp_q.push_back(ram_model[(int'(sa) + i) % Depth]);
    start      = 1'b1;
    start_addr = sa;
    length     = (W+1)'(len);
    @(negedge clk);
    start    = 1'b0;
    k        = 0;
    hs_cnt   = 0;
    hs_k     = -100;
    first_k  = -1;
    pending  = 1'b0;
    finished = 1'b0;
    held     = '0;
    while (!finished && k < 6 * len + 64) begin
      start = (k == restart_k);
      if (start) begin
        start_addr = sa + W'(5);
        length     = 11'd3;
      end
      if (done) begin
        checks++;
        if (hs_cnt != len || k != hs_k + 1) begin
          errors++;
          $display("FAIL %s done_timing got words=%0d cycle=%0d want words=%0d cycle=%0d",
                   name, hs_cnt, k, len, hs_k + 1);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got %b want 0", name, busy); end
        checks++;
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL %s valid_at_done got %b want 0", name, out_valid);
        end
        finished = 1'b1;
      end else begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy k=%0d got %b want 1", name, k, busy); end
        if (hs_cnt > 0 && k == hs_k + 1) begin
          checks++;
          if (out_valid !== 1'b0) begin
            errors++; $display("FAIL %s gap k=%0d got valid=%b want 0", name, k, out_valid);
          end
        end
        if (out_valid) begin
          if (first_k < 0) first_k = k;
          if (!pending) begin
            exp_k = (hs_cnt == 0) ? 1 : hs_k + 2;
            checks++;
            if (k != exp_k) begin
              errors++; $display("FAIL %s valid_timing got cycle %0d want %0d", name, k, exp_k);
            end
          end else begin
            checks++;
            if (out_data !== held) begin
              errors++; $display("FAIL %s stable k=%0d got %h want %h", name, k, out_data, held);
            end
          end
          checks++;
          if (hs_cnt >= len || out_data !== exp_q[hs_cnt]) begin
            errors++;
            $display("FAIL %s data word=%0d got %h want %h", name, hs_cnt, out_data,
                     (hs_cnt < len) ? exp_q[hs_cnt] : 'x);
          end
        end
        if (rand_ready) rdy = 1'($urandom_range(0, 1));
        else rdy = !(first_k >= 0 && k < first_k + stall_len);
        if (out_valid && rdy) begin
          hs_cnt++;
          hs_k    = k;
          pending = 1'b0;
        end else if (out_valid) begin
          pending = 1'b1;
          held    = out_data;
        end
        out_ready = rdy;
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    if (!finished) begin
      checks++; errors++;
      $display("FAIL %s timeout got words=%0d want %0d", name, hs_cnt, len);
    end
  endtask

  task automatic test_basic_burst();
    run_burst(10'd2, 4, 0, 1'b0, -1, "basic");
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_after got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_stall();
    run_burst(10'd2, 4, 5, 1'b0, -1, "stall");
    @(negedge clk);
  endtask

  task automatic test_wrap();
    host_write(10'd1022, 32'h1, '1);
    host_write(10'd1023, 32'h2, '1);
    host_write(10'd0, 32'h3, '1);
    host_write(10'd1, 32'h4, '1);
    run_burst(10'd1022, 4, 0, 1'b0, -1, "wrap");
    @(negedge clk);
  endtask

  task automatic test_zero_len();
    start      = 1'b1;
    start_addr = W'($urandom_range(0, Depth - 1));
    length     = '0;
    out_ready  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_len got done=%b busy=%b valid=%b want 1 0 0", done, busy, out_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL zero_len_after got done=%b valid=%b want 0 0", done, out_valid);
    end
  endtask

  task automatic test_start_while_busy();
    run_burst(10'd100, 3, 0, 1'b0, 2, "busy_start");
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_after got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    run_burst(10'd200, 3, 0, 1'b0, -1, "b2b_first");
    run_burst(10'd300, 2, 0, 1'b0, -1, "b2b_second");
    @(negedge clk);
  endtask

  task automatic test_abort();
    start      = 1'b1;
    start_addr = 10'd400;
    length     = 11'd4;
    out_ready  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL abort_pre got valid=%b want 1", out_valid); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL abort_post%0d got valid=%b busy=%b done=%b want 0 0 0",
                 i, out_valid, busy, done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_burst();
    start      = 1'b1;
    start_addr = 10'd500;
    length     = 11'd6;
    out_ready  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b done=%b valid=%b data=%h want 0 0 0 0",
               busy, done, out_valid, out_data);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_after got busy=%b valid=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      for (int m = 0; m < 3; m++) host_write(W'($urandom_range(0, Depth - 1)), $urandom, '1);
      run_burst(W'($urandom_range(0, Depth - 1)), $urandom_range(1, 16), 0, 1'b1, -1, "random");
      @(negedge clk);
    end
  endtask

  task automatic test_full_length();
    run_burst(W'($urandom_range(0, Depth - 1)), int'(Depth), 0, 1'b0, -1, "full");
    @(negedge clk);
  endtask

`ifdef RAM_SRC_BYTEEN_EN
  task automatic test_byteen();
    logic [W-1:0] a;
    host_write(10'd10, 32'h1122_3344, 4'hF);
    host_write(10'd10, 32'hFFFF_FFFF, 4'b0010);
    address = 10'd10;
    @(negedge clk);
    checks++;
    if (readdata !== 32'h1122_FF44) begin
      errors++; $display("FAIL byteen got %h want 1122ff44", readdata);
    end
    for (int j = 0; j < 4; j++) begin
      a = W'($urandom_range(0, Depth - 1));
      host_write(a, $urandom, 4'($urandom_range(0, 15)));
      address = a;
      @(negedge clk);
      checks++;
      if (readdata !== ram_model[a]) begin
        errors++; $display("FAIL byteen_rand addr=%0d got %h want %h", a, readdata, ram_model[a]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    fill_ram();
    test_host_rw();
    test_write_visibility();
    test_basic_burst();
    test_stall();
    test_wrap();
    test_zero_len();
    test_start_while_busy();
    test_back_to_back();
    test_abort();
    test_reset_mid_burst();
    test_random();
    test_full_length();
`ifdef RAM_SRC_BYTEEN_EN
    test_byteen();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
